// File: rtl/data_mem_mmio.sv
// data_mem_mmio: CPU data-memory responder; word RAM plus an MMIO page with a TX byte FIFO.
// Define DATA_MEM_TIMER_EN to add the CYCLE/TIMECMP timer and timer_irq.
module data_mem_mmio #(
  parameter int          RAM_DEPTH  = 1024,
  parameter logic [19:0] MMIO_PAGE  = 20'h10000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        timer_irq
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [31:0] mem_q [RAM_DEPTH];
  logic [7:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic mmio, hit_tx, hit_st, empty, full, push, pop, accept;
  logic [31:0] mmio_rd;
  logic unused_ok;
  assign unused_ok = ^Mem_WrAddr[1:0];
  assign mmio = Mem_WrAddr[31:12] == MMIO_PAGE;
  assign hit_tx = mmio & (Mem_WrAddr[11:2] == 10'h000);
  assign hit_st = mmio & (Mem_WrAddr[11:2] == 10'h001);
  assign empty = cnt_q == '0;
  assign full = cnt_q == (PW+1)'(FIFO_DEPTH);
  assign push = MemWrite & hit_tx;
  assign pop = tx_valid & tx_ready;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign accept = push & (!full | pop);
  assign tx_valid = !empty;
  assign tx_data = fifo_q[rd_ptr_q];
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(accept);
    cnt_d = cnt_q + (PW+1)'(accept) - (PW+1)'(pop);
    ovf_d = (push & !accept) | (ovf_q & !(MemWrite & hit_st & Mem_WrData[0]));
  end
  always_ff @(posedge clk) begin
    if (MemWrite & !mmio) mem_q[Mem_WrAddr[AW+1:2]] <= Mem_WrData;
    if (accept) fifo_q[wr_ptr_q] <= Mem_WrData[7:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
`ifdef DATA_MEM_TIMER_EN
  logic hit_cy, hit_cmp, irq_q, irq_d;
  logic [31:0] cycle_q, cycle_d, cmp_q, cmp_d;
  assign hit_cy = mmio & (Mem_WrAddr[11:2] == 10'h002);
  assign hit_cmp = mmio & (Mem_WrAddr[11:2] == 10'h003);
  always_comb begin
    cycle_d = (MemWrite & hit_cy) ? Mem_WrData : cycle_q + 32'd1;
    cmp_d = (MemWrite & hit_cmp) ? Mem_WrData : cmp_q;
    irq_d = cycle_q >= cmp_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      cmp_q <= 32'hFFFF_FFFF;
      irq_q <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      cmp_q <= cmp_d;
      irq_q <= irq_d;
    end
  end
  assign timer_irq = irq_q;
  assign mmio_rd = hit_st ? {29'b0, ovf_q, full, empty} : hit_cy ? cycle_q : hit_cmp ? cmp_q : '0;
`else
  assign timer_irq = 1'b0;
  assign mmio_rd = hit_st ? {29'b0, ovf_q, full, empty} : '0;
`endif
  assign ReadData = mmio ? mmio_rd : mem_q[Mem_WrAddr[AW+1:2]];
endmodule
